// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rsa_pkg
// Purpose  : Definitions shared by the RSA key-path blocks (CRT recombine,
//            modular inverse, exponentiators).
//            - crt_state_e    : recombination sequencer states
//            - KEY_HALF_WIDTH : default half-width of the RSA modulus
// Revision : 1.0 - initial release
// ============================================================================
package rsa_pkg;

  localparam int KEY_HALF_WIDTH = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MODMUL = 3'd1,
    ST_DIFF   = 3'd2,
    ST_MUL    = 3'd3,
    ST_FINAL  = 3'd4
  } crt_state_e;

endpackage : rsa_pkg
`default_nettype wire

// File: rtl/crt_recombine_if.sv
`default_nettype none
// ============================================================================
// Module   : crt_recombine_if
// Purpose  : Request/result bundle of the CRT recombination block.
//            master : drives start, p, q, qinv, m1, m2; receives m, busy, done
//            slave  : the recombination block itself
// Ports    : (signals)
//            start        one-cycle request
//            p, q, qinv   primes and q^-1 mod p         (WIDTH)
//            m1, m2       residues mod p and mod q      (WIDTH)
//            m            recombined plaintext          (2*WIDTH)
//            busy, done   status / one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
interface crt_recombine_if #(
  parameter int WIDTH = 512
);
  logic                 start;
  logic [WIDTH-1:0]     p;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qinv;
  logic [WIDTH-1:0]     m1;
  logic [WIDTH-1:0]     m2;
  logic [2*WIDTH-1:0]   m;
  logic                 busy;
  logic                 done;

  modport master (
    output start, p, q, qinv, m1, m2,
    input  m, busy, done
  );

  modport slave (
    input  start, p, q, qinv, m1, m2,
    output m, busy, done
  );

endinterface : crt_recombine_if
`default_nettype wire

// File: rtl/mod_mul_serial.sv
`default_nettype none
// ============================================================================
// Module   : mod_mul_serial
// Purpose  : Bit-serial interleaved modular multiplier, result = a*b mod n.
//            One multiplier bit (MSB first) is consumed per cycle; after
//            WIDTH steps following a load, result holds a*b mod n.
//            The unit free-runs after that; the owner samples result at the
//            right cycle.
// Ports    : clk    rising-edge clock
//            rst    synchronous active-high reset
//            load   capture a, clear the remainder
//            a      multiplier, scanned bitwise (may exceed n)
//            b      multiplicand, must be < n, held stable while stepping
//            n      modulus, held stable while stepping
//            result running remainder R (< n)
// Revision : 1.0 - initial release
// ============================================================================
module mod_mul_serial
  import rsa_pkg::*;
#(
  parameter int WIDTH = KEY_HALF_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic [WIDTH-1:0] n,
  output logic      [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH+1:0] sum_w;
  logic [WIDTH+1:0] red_w;
  logic [WIDTH+1:0] n1_w;
  logic [WIDTH+1:0] n2_w;

  // R < n and b < n give 2R + b < 3n, so at most one subtraction of
  // either 2n or n restores R < n.
  always_comb begin
    n1_w  = {2'b00, n};
    n2_w  = {1'b0, n, 1'b0};
    sum_w = {1'b0, r_q, 1'b0} + (a_q[WIDTH-1] ? {2'b00, b} : '0);
    if (sum_w >= n2_w) begin
      red_w = sum_w - n2_w;
    end else if (sum_w >= n1_w) begin
      red_w = sum_w - n1_w;
    end else begin
      red_w = sum_w;
    end

    a_d = {a_q[WIDTH-2:0], 1'b0};
    r_d = WIDTH'(red_w);
    if (load) begin
      a_d = a;
      r_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      r_q <= '0;
    end else begin
      a_q <= a_d;
      r_q <= r_d;
    end
  end

  assign result = r_q;

endmodule : mod_mul_serial
`default_nettype wire

// File: rtl/crt_recombine.sv
`default_nettype none
// ============================================================================
// Module   : crt_recombine
// Purpose  : Garner CRT recombination, m = m2 + q*(((m1 - m2)*qinv) mod p),
//            fully bit-serial, no divider.
//            MODMUL : x = m1*qinv mod p, y = m2*qinv mod p  (WIDTH cycles)
//            DIFF   : h = (x - y) mod p                     (1 cycle)
//            MUL    : acc = h*q, shift-add MSB first        (WIDTH cycles)
//            FINAL  : m = acc + m2, done pulse              (1 cycle)
// Ports    : clk   rising-edge clock
//            rst   synchronous active-high reset, overrides everything
//            bus   crt_recombine_if.slave (start, p, q, qinv, m1, m2 in;
//                  m, busy, done out)
// Revision : 1.0 - initial release
// ============================================================================
module crt_recombine
  import rsa_pkg::*;
#(
  parameter int WIDTH = KEY_HALF_WIDTH
) (
  input wire logic        clk,
  input wire logic        rst,
  crt_recombine_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  crt_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   qinv_q, qinv_d;
  logic [WIDTH-1:0]   m2_q, m2_d;
  logic [WIDTH-1:0]   h_q, h_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] m_q, m_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load_w;
  logic [WIDTH-1:0]   x_w;
  logic [WIDTH-1:0]   y_w;

  // Multipliers capture m1/m2 straight from the bus on the accepting edge;
  // qinv and p reach them from the latched copies one edge later, in time
  // for the first step.
  assign load_w = (state_q == ST_IDLE) && bus.start;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_x (
    .clk    (clk),
    .rst    (rst),
    .load   (load_w),
    .a      (bus.m1),
    .b      (qinv_q),
    .n      (p_q),
    .result (x_w)
  );

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul_y (
    .clk    (clk),
    .rst    (rst),
    .load   (load_w),
    .a      (bus.m2),
    .b      (qinv_q),
    .n      (p_q),
    .result (y_w)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    qinv_d  = qinv_q;
    m2_d    = m2_q;
    h_d     = h_q;
    acc_d   = acc_q;
    m_d     = m_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          p_d     = bus.p;
          q_d     = bus.q;
          qinv_d  = bus.qinv;
          m2_d    = bus.m2;
          h_d     = '0;
          acc_d   = '0;
          cnt_d   = CNT_LAST;
          busy_d  = 1'b1;
          state_d = ST_MODMUL;
        end
      end

      ST_MODMUL: begin
        if (cnt_q == '0) begin
          state_d = ST_DIFF;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_DIFF: begin
        // Both x and y are < p, so WIDTH-bit wraparound of x - y + p
        // lands exactly on the true value in [0, p).
        if (x_w < y_w) begin
          h_d = x_w - y_w + p_q;
        end else begin
          h_d = x_w - y_w;
        end
        acc_d   = '0;
        cnt_d   = CNT_LAST;
        state_d = ST_MUL;
      end

      ST_MUL: begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0}
              + (h_q[WIDTH-1] ? {{WIDTH{1'b0}}, q_q} : '0);
        h_d   = {h_q[WIDTH-2:0], 1'b0};
        if (cnt_q == '0) begin
          state_d = ST_FINAL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FINAL: begin
        m_d     = acc_q + {{WIDTH{1'b0}}, m2_q};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      qinv_q  <= '0;
      m2_q    <= '0;
      h_q     <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      qinv_q  <= qinv_d;
      m2_q    <= m2_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.m    = m_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule : crt_recombine
`default_nettype wire

// File: tb/tb_crt_recombine.sv
`default_nettype none
// ============================================================================
// Module   : tb_crt_recombine
// Purpose  : Self-checking bench for crt_recombine. A WIDTH=8 instance runs
//            the directed cases (worked example, maximum value, zero/equal
//            residues, start re-pulse, mid-run reset); a WIDTH=16 instance
//            runs random plaintexts against a CRT reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_crt_recombine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crt_recombine_if #(.WIDTH(8))  if8  ();
  crt_recombine_if #(.WIDTH(16)) if16 ();

  crt_recombine #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  crt_recombine #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: the unique m in [0, p*q) with m = m1 mod p and m = m2 mod q,
  // found by walking the m2 residue class mod q.
  function automatic longint crt_ref(longint r1, longint r2, longint pp,
                                     longint qq);
    longint cand = r2;
    for (int i = 0; i < pp; i++) begin
      if (cand % pp == r1) return cand;
      cand += qq;
    end
    return -1;
  endfunction

  task automatic run8(input logic [7:0] a1, input logic [7:0] a2,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    if8.p = 8'd11; if8.q = 8'd13; if8.qinv = 8'd6;
    if8.m1 = a1;   if8.m2 = a2;   if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = if8.m;
  endtask

  task automatic run16(input logic [15:0] qi, input logic [15:0] a1,
                       input logic [15:0] a2,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    if16.p = 16'd251; if16.q = 16'd65521; if16.qinv = qi;
    if16.m1 = a1;     if16.m2 = a2;       if16.start = 1'b1;
    @(negedge clk);
    if16.start = 1'b0;
    lat = 0;
    while (!if16.done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = if16.m;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r8;
    logic [31:0] r16;
    logic [15:0] qinv16;
    int          lat;
    int          dones;
    int          first_done;
    logic        busy_ok;

    rst = 1'b1;
    if8.start  = 1'b0; if8.p  = '0; if8.q  = '0; if8.qinv  = '0;
    if8.m1     = '0;   if8.m2 = '0;
    if16.start = 1'b0; if16.p = '0; if16.q = '0; if16.qinv = '0;
    if16.m1    = '0;   if16.m2 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_m8",    64'(if8.m),    64'd0);
    check_val("rst_busy8", 64'(if8.busy), 64'd0);
    check_val("rst_done8", 64'(if8.done), 64'd0);
    check_val("rst_m16",   64'(if16.m),   64'd0);
    rst = 1'b0;

    // Worked example
    run8(8'd1, 8'd9, r8, lat);
    check_val("ex_m",   64'(r8),  64'(crt_ref(1, 9, 11, 13)));
    check_val("ex_m_c", 64'(r8),  64'd100);
    check_val("ex_lat", 64'(lat), 64'd18);
    @(negedge clk);
    check_val("ex_done_pulse", 64'(if8.done), 64'd0);

    // Maximum value, negative difference wrap
    run8(8'd10, 8'd12, r8, lat);
    check_val("max_m",   64'(r8),  64'd142);
    check_val("max_lat", 64'(lat), 64'd18);

    // Zero and equal residues
    run8(8'd0, 8'd0, r8, lat);
    check_val("zero_m", 64'(r8), 64'd0);
    run8(8'd5, 8'd5, r8, lat);
    check_val("eq_m",   64'(r8),  64'd5);
    check_val("eq_lat", 64'(lat), 64'd18);

    // start re-pulsed mid-run with changed inputs
    @(negedge clk);
    if8.p = 8'd11; if8.q = 8'd13; if8.qinv = 8'd6;
    if8.m1 = 8'd1; if8.m2 = 8'd9; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    dones = 0; first_done = 0; busy_ok = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (if8.done) begin
        dones++;
        if (first_done == 0) first_done = c;
      end
      if (first_done == 0 && !if8.busy) busy_ok = 1'b0;
      if (c == 3 || c == 10) begin
        if8.start = 1'b1; if8.m1 = 8'd7; if8.m2 = 8'd3; if8.qinv = 8'd2;
      end else begin
        if8.start = 1'b0;
      end
    end
    check_val("repulse_dones", 64'(dones),      64'd1);
    check_val("repulse_cycle", 64'(first_done), 64'd18);
    check_val("repulse_m",     64'(if8.m),      64'd100);
    check_val("repulse_busy",  64'(busy_ok),    64'd1);

    // Reset mid-operation
    @(negedge clk);
    if8.p = 8'd11; if8.q = 8'd13; if8.qinv = 8'd6;
    if8.m1 = 8'd10; if8.m2 = 8'd12; if8.start = 1'b1;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_m",    64'(if8.m),    64'd0);
    check_val("midrst_busy", 64'(if8.busy), 64'd0);
    check_val("midrst_done", 64'(if8.done), 64'd0);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if8.done) dones++;
    end
    check_val("midrst_no_done", 64'(dones), 64'd0);
    run8(8'd1, 8'd9, r8, lat);
    check_val("after_rst_m",   64'(r8),  64'd100);
    check_val("after_rst_lat", 64'(lat), 64'd18);

    // Random plaintexts, WIDTH=16
    qinv16 = '0;
    for (int i = 1; i < 251; i++) begin
      if ((65521 * i) % 251 == 1) qinv16 = 16'(i);
    end
    for (int v = 0; v < 1000; v++) begin
      longint big_m;
      big_m = longint'($urandom % 32'(251 * 65521));
      run16(qinv16, 16'(big_m % 251), 16'(big_m % 65521), r16, lat);
      check_val("rand_m",   64'(r16), 64'(big_m));
      check_val("rand_lat", 64'(lat), 64'd34);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_crt_recombine
`default_nettype wire
